rx_commit_pacer: RTL and testbench

RX_COMMIT_PACER -- requirements
Module: rx_commit_pacer

---
 rtl/rx_commit_pacer.sv | 140 ++++++++++++++
 tb/tb_rx_commit_pacer.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rx_commit_pacer.sv
// ============================================================================
// rx_commit_pacer
// Accumulates written frame bytes and publishes them to a committed write
// address, paced by size/age/flush triggers and a minimum holdoff.
// Revision: 1.0
// ============================================================================
`default_nettype none

`ifndef BF
`define BF 15
`endif

module rx_commit_pacer #(
  parameter int unsigned COALESCE = 256,
  parameter int unsigned MAX_AGE  = 64,
  parameter int unsigned HOLDOFF  = 8
) (
  input  logic          clk_in,
  input  logic          reset_n_clk_in,
  input  logic          enable,
  input  logic          frame_done,
  input  logic [15:0]   frame_len,
  input  logic          flush,
  output logic [`BF:0]  commited_wr_address,
  output logic          publish_pulse,
  output logic [`BF:0]  pending_bytes,
  output logic          overflow_err
);

  localparam int unsigned W           = `BF + 1;
  localparam logic [7:0]  C_HOLD_LOAD = 8'(HOLDOFF - 2);
  localparam logic [15:0] C_AGE_MAX   = 16'hFFFF;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  state_t       r_state;
  logic [15:0]  r_age;
  logic         r_flush_pend;
  logic [7:0]   r_hold_cnt;

  logic         w_frame;
  logic         w_trigger;
  logic         w_sat;
  logic         w_ovf;
  logic [W-1:0] w_len;
  logic [W:0]   w_sum;
  logic [W-1:0] w_pend_nxt;
  logic [15:0]  w_age_nxt;

  always_comb begin
    w_frame   = frame_done && (frame_len != 16'd0);
    w_trigger = (r_state == S_ACCUM) && enable &&
                ((32'(pending_bytes) >= COALESCE) ||
                 (32'(r_age) >= MAX_AGE) ||
                 r_flush_pend);
    w_len     = W'(frame_len);
    w_sum     = {1'b0, pending_bytes} + {1'b0, w_len};
    w_sat     = w_sum[W];
    w_ovf     = 1'b0;

    // A frame landing on the publish edge starts a fresh batch on its own.
    if (w_trigger) begin
      w_pend_nxt = w_frame ? w_len : '0;
    end else if (w_frame) begin
      w_pend_nxt = w_sat ? '1 : w_sum[W-1:0];
      w_ovf      = w_sat;
    end else begin
      w_pend_nxt = pending_bytes;
    end

    if ((w_pend_nxt == '0) || w_trigger || (pending_bytes == '0)) begin
      w_age_nxt = 16'd0;
    end else if (r_age == C_AGE_MAX) begin
      w_age_nxt = r_age;
    end else begin
      w_age_nxt = r_age + 16'd1;
    end
  end

  always_ff @(posedge clk_in or negedge reset_n_clk_in) begin
    if (!reset_n_clk_in) begin
      r_state             <= S_IDLE;
      r_age               <= 16'd0;
      r_flush_pend        <= 1'b0;
      r_hold_cnt          <= 8'd0;
      commited_wr_address <= '0;
      publish_pulse       <= 1'b0;
      pending_bytes       <= '0;
      overflow_err        <= 1'b0;
    end else begin
      publish_pulse <= w_trigger;
      pending_bytes <= w_pend_nxt;
      r_age         <= w_age_nxt;
      overflow_err  <= overflow_err | w_ovf;

      if (w_trigger) begin
        commited_wr_address <= commited_wr_address + pending_bytes;
      end

      // A flush with nothing pending has nothing to publish and is dropped.
      if (w_trigger) begin
        r_flush_pend <= 1'b0;
      end else if (flush && (pending_bytes != '0)) begin
        r_flush_pend <= 1'b1;
      end

      case (r_state)
        S_IDLE: begin
          if (w_pend_nxt != '0) begin
            r_state <= S_ACCUM;
          end
        end
        S_ACCUM: begin
          if (w_trigger) begin
            r_state    <= S_HOLD;
            r_hold_cnt <= C_HOLD_LOAD;
          end
        end
        S_HOLD: begin
          // HOLDOFF-1 cycles here plus the evaluating ACCUM cycle give the spacing.
          if (r_hold_cnt == 8'd0) begin
            r_state <= (w_pend_nxt != '0) ? S_ACCUM : S_IDLE;
          end else begin
            r_hold_cnt <= r_hold_cnt - 8'd1;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_rx_commit_pacer.sv
// ============================================================================
// tb_rx_commit_pacer
// Scoreboard bench: a cycle-level reference model queues expected publishes,
// a negedge monitor compares every DUT output against it.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_rx_commit_pacer;

  localparam int COALESCE = 256;
  localparam int MAX_AGE  = 64;
  localparam int HOLDOFF  = 8;

  logic        clk_in = 1'b0;
  logic        reset_n_clk_in = 1'b0;
  logic        enable = 1'b0;
  logic        frame_done = 1'b0;
  logic [15:0] frame_len = 16'd0;
  logic        flush = 1'b0;
  logic [15:0] commited_wr_address;
  logic        publish_pulse;
  logic [15:0] pending_bytes;
  logic        overflow_err;

  rx_commit_pacer #(
    .COALESCE(COALESCE),
    .MAX_AGE (MAX_AGE),
    .HOLDOFF (HOLDOFF)
  ) dut (
    .clk_in             (clk_in),
    .reset_n_clk_in     (reset_n_clk_in),
    .enable             (enable),
    .frame_done         (frame_done),
    .frame_len          (frame_len),
    .flush              (flush),
    .commited_wr_address(commited_wr_address),
    .publish_pulse      (publish_pulse),
    .pending_bytes      (pending_bytes),
    .overflow_err       (overflow_err)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    int          cyc;
    logic [15:0] addr;
  } pub_t;

  pub_t q[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;

  // Reference state: what the outputs should show in the current cycle.
  int          m_pend;
  int          m_addr;
  bit          m_ovf;
  bit          m_flush;
  int          m_birth;
  int          m_last_pub;

  always @(posedge clk_in) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_clear();
    m_pend     = 0;
    m_addr     = 0;
    m_ovf      = 0;
    m_flush    = 0;
    m_birth    = 0;
    m_last_pub = -1000;
  endtask

  always @(negedge clk_in) begin
    chk("pending_bytes", 32'(pending_bytes), 32'(m_pend));
    chk("overflow_err", 32'(overflow_err), 32'(m_ovf));
    chk("commited_wr_address", 32'(commited_wr_address), 32'(m_addr));
    if (publish_pulse === 1'b1) begin
      checks++;
      if (q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_publish: got pulse at cycle %0d expected none", cyc);
      end else begin
        pub_t e;
        e = q.pop_front();
        chk("publish_cycle", 32'(cyc), 32'(e.cyc));
        chk("publish_addr", 32'(commited_wr_address), 32'(e.addr));
      end
    end else if (q.size() > 0 && q[0].cyc <= cyc) begin
      pub_t e;
      e = q.pop_front();
      checks++;
      failures++;
      $display("FAIL missed_publish: got no pulse expected pulse at cycle %0d", e.cyc);
    end
  end

  // One clock of stimulus; the model decides from the pre-edge view.
  task automatic step(input logic en, input logic fd, input logic [15:0] len, input logic fl);
    int   n_pend, n_addr, n_birth, n_last, age, sum;
    bit   n_ovf, n_flush, pub, frm;
    pub_t e;
    enable     = en;
    frame_done = fd;
    frame_len  = len;
    flush      = fl;
    frm        = fd && (len != 16'd0);
    age        = (cyc - m_birth > 65535) ? 65535 : (cyc - m_birth);
    pub        = en && (m_pend > 0) && (cyc - m_last_pub >= HOLDOFF) &&
                 (m_pend >= COALESCE || age >= MAX_AGE || m_flush);
    n_pend = m_pend; n_addr = m_addr; n_birth = m_birth; n_last = m_last_pub;
    n_ovf  = m_ovf;  n_flush = m_flush;
    if (pub) begin
      n_addr  = (m_addr + m_pend) % 65536;
      n_pend  = frm ? int'(len) : 0;
      n_birth = cyc + 1;
      n_flush = 0;
      n_last  = cyc;
      e.cyc   = cyc + 1;
      e.addr  = 16'(n_addr);
      q.push_back(e);
    end else begin
      if (frm) begin
        if (m_pend == 0) n_birth = cyc + 1;
        sum = m_pend + int'(len);
        if (sum > 65535) begin
          n_pend = 65535;
          n_ovf  = 1;
        end else begin
          n_pend = sum;
        end
      end
      if (fl && m_pend > 0) n_flush = 1;
    end
    @(posedge clk_in);
    #1;
    m_pend = n_pend; m_addr = n_addr; m_birth = n_birth; m_last_pub = n_last;
    m_ovf  = n_ovf;  m_flush = n_flush;
  endtask

  task automatic idle(input int n, input logic en);
    for (int i = 0; i < n; i++) step(en, 1'b0, 16'd0, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk_in);
    #1;
    reset_n_clk_in = 1'b0;
    enable = 1'b0; frame_done = 1'b0; frame_len = 16'd0; flush = 1'b0;
    q.delete();
    model_clear();
    repeat (3) @(posedge clk_in);
    #1;
    reset_n_clk_in = 1'b1;
  endtask

  initial begin
    model_clear();
    repeat (3) @(posedge clk_in);
    #1;
    reset_n_clk_in = 1'b1;
    chk("reset_addr", 32'(commited_wr_address), 32'h0);
    chk("reset_pending", 32'(pending_bytes), 32'h0);
    chk("reset_pulse", 32'(publish_pulse), 32'h0);

    // Large frame publishes two cycles after its strobe.
    idle(2, 1'b1);
    step(1'b1, 1'b1, 16'd300, 1'b0);
    chk("l300_pulse_t1", 32'(publish_pulse), 32'h0);
    idle(1, 1'b1);
    chk("l300_pulse_t2", 32'(publish_pulse), 32'h1);
    chk("l300_addr", 32'(commited_wr_address), 32'd300);
    chk("l300_pending", 32'(pending_bytes), 32'h0);
    idle(10, 1'b1);

    // Small frame waits for the age trigger.
    do_reset();
    step(1'b1, 1'b1, 16'd100, 1'b0);
    idle(64, 1'b1);
    chk("age_pulse_t65", 32'(publish_pulse), 32'h0);
    idle(1, 1'b1);
    chk("age_pulse_t66", 32'(publish_pulse), 32'h1);
    chk("age_addr", 32'(commited_wr_address), 32'd100);
    idle(10, 1'b1);

    // Back-to-back frames: holdoff-limited publishes draining to 2560.
    do_reset();
    for (int i = 0; i < 40; i++) step(1'b1, 1'b1, 16'd64, 1'b0);
    idle(120, 1'b1);
    chk("stream_final_addr", 32'(commited_wr_address), 32'd2560);

    // Address wrap.
    do_reset();
    step(1'b1, 1'b1, 16'hFF00, 1'b0);
    idle(12, 1'b1);
    chk("wrap_base", 32'(commited_wr_address), 32'hFF00);
    step(1'b1, 1'b1, 16'h0200, 1'b0);
    idle(12, 1'b1);
    chk("wrap_addr", 32'(commited_wr_address), 32'h0100);

    // Enable low holds everything off, including flush and age.
    do_reset();
    step(1'b0, 1'b1, 16'd50, 1'b0);
    step(1'b0, 1'b0, 16'd0, 1'b1);
    idle(200, 1'b0);
    chk("disabled_addr", 32'(commited_wr_address), 32'h0);
    step(1'b1, 1'b0, 16'd0, 1'b0);
    chk("enable_pulse", 32'(publish_pulse), 32'h1);
    chk("enable_addr", 32'(commited_wr_address), 32'd50);
    idle(10, 1'b1);

    // Saturating accumulation, then reset while holding off.
    do_reset();
    step(1'b0, 1'b1, 16'hFF80, 1'b0);
    step(1'b0, 1'b1, 16'h0100, 1'b0);
    idle(2, 1'b0);
    chk("sat_pending", 32'(pending_bytes), 32'hFFFF);
    chk("sat_overflow", 32'(overflow_err), 32'h1);
    step(1'b1, 1'b1, 16'd40, 1'b0);
    chk("sat_publish", 32'(publish_pulse), 32'h1);
    chk("sat_overflow_sticky", 32'(overflow_err), 32'h1);
    idle(2, 1'b1);
    do_reset();
    chk("hold_reset_addr", 32'(commited_wr_address), 32'h0);
    chk("hold_reset_pending", 32'(pending_bytes), 32'h0);
    chk("hold_reset_ovf", 32'(overflow_err), 32'h0);
    chk("hold_reset_pulse", 32'(publish_pulse), 32'h0);
    idle(20, 1'b1);

    // Randomised traffic against the model.
    do_reset();
    for (int i = 0; i < 2000; i++) begin
      logic        en, fd, fl;
      logic [15:0] len;
      int          r;
      en = ($urandom_range(0, 9) != 0);
      fd = ($urandom_range(0, 2) == 0);
      r  = $urandom_range(0, 19);
      if (r == 0)      len = 16'd0;
      else if (r == 1) len = 16'($urandom_range(0, 65535));
      else             len = 16'($urandom_range(1, 300));
      fl = ($urandom_range(0, 19) == 0);
      step(en, fd, len, fl);
    end
    idle(150, 1'b1);

    if (q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL publish_queue_drain: got %0d outstanding expected 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
